// File: rtl/chronos_testrig_pkg.sv
// -----------------------------------------------------------------------------
// chronos_testrig_pkg
//   Shared definitions for the test-rig host that decodes the serial tohost
//   line coming out of a simulated core.
//
//   state_e      : host FSM states
//   FRAME_BITS   : start + payload + parity + stop bits in one frame
//   PAYLOAD_BITS : data bits per frame
//   EXIT_BIT     : payload bit that marks an exit command instead of a word
// -----------------------------------------------------------------------------
package chronos_testrig_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        HOLD   = 3'd4,
        HALT   = 3'd5
    } state_e;

    localparam int FRAME_BITS   = 35;
    localparam int PAYLOAD_BITS = FRAME_BITS - 3;
    localparam int EXIT_BIT     = 0;

endpackage : chronos_testrig_pkg

// File: rtl/testrig_rx_shift.sv
// -----------------------------------------------------------------------------
// testrig_rx_shift
//   Receive datapath for one tohost frame: an LSB-first shift register, a bit
//   counter that flags the last payload bit, and a running XOR over the payload
//   and parity bit.
//
//   clk          : rising-edge clock
//   rst          : asynchronous active-low reset
//   clear_i      : start of a new frame; drop everything collected so far
//   shift_i      : bit_i is a payload bit, shift it in
//   parity_i     : bit_i is the parity bit, fold it into the XOR only
//   bit_i        : current value of the serial line
//   data_o       : assembled payload (complete once the last bit is shifted)
//   last_o       : the bit being shifted this cycle is the final payload bit
//   parity_ok_o  : XOR of payload and parity bit is zero (even parity)
// -----------------------------------------------------------------------------
module testrig_rx_shift
    import chronos_testrig_pkg::*;
#(
    parameter int DATA_W = PAYLOAD_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              shift_i,
    input  logic              parity_i,
    input  logic              bit_i,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o,
    output logic              parity_ok_o
);

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;
    logic              par_q,  par_d;

    // NOTE: every _d is given its current value before any branch, so no path
    // through this block leaves a signal unassigned and infers a latch.
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        par_d  = par_q;

        if (clear_i) begin
            data_d = '0;
            cnt_d  = '0;
            par_d  = 1'b0;
        end else if (shift_i) begin
            // First bit received ends up in bit 0 after DATA_W shifts.
            data_d = {bit_i, data_q[DATA_W-1:1]};
            cnt_d  = cnt_q + CNT_W'(1);
            par_d  = par_q ^ bit_i;
        end else if (parity_i) begin
            par_d  = par_q ^ bit_i;
        end
    end

    // NOTE: the payload register is reset along with the control state, so a
    // frame cut short by reset can never leak partial bits into a later word.
    // NOTE: registers are written with non-blocking assignments only; all
    // next-state arithmetic stays in the always_comb block above.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            cnt_q  <= '0;
            par_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            par_q  <= par_d;
        end
    end

    assign data_o      = data_q;
    assign last_o      = (cnt_q == CNT_LAST);
    assign parity_ok_o = ~par_q;

endmodule : testrig_rx_shift

// File: rtl/testrig_host.sv
// -----------------------------------------------------------------------------
// testrig_host
//   Host side of the core test rig. Decodes frames on the serial tohost line
//   (start 0, 32 data bits LSB first, even parity, stop 1; one bit per clk),
//   hands data words to a valid/ready consumer, latches exit commands, flags
//   protocol errors and halts everything when the watchdog expires.
//
//   Parameters
//     TIMEOUT : cycles after reset release before the watchdog halts the host
//     DATA_W  : payload width (32 only)
//
//   Ports
//     clk              : rising-edge clock
//     rst              : asynchronous active-low reset
//     testrig_tohost   : serial line from the core, idles high
//     testrig_fromhost : high only in IDLE; core may start a frame
//     word_valid       : decoded data word available
//     word_data        : decoded data word
//     word_ready       : consumer accepts word_data
//     exit_valid       : sticky, core issued an exit command
//     exit_code        : exit payload (data[31:1])
//     proto_err        : sticky protocol error
//     timeout          : sticky watchdog expiry
// -----------------------------------------------------------------------------
module testrig_host
    import chronos_testrig_pkg::*;
#(
    parameter int TIMEOUT = 1000,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              testrig_tohost,
    output logic              testrig_fromhost,
    output logic              word_valid,
    output logic [DATA_W-1:0] word_data,
    input  logic              word_ready,
    output logic              exit_valid,
    output logic [DATA_W-2:0] exit_code,
    output logic              proto_err,
    output logic              timeout
);

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_e            state_q,      state_d;
    logic              fromhost_q,   fromhost_d;
    logic              word_valid_q, word_valid_d;
    logic [DATA_W-1:0] word_data_q,  word_data_d;
    logic              exit_valid_q, exit_valid_d;
    logic [DATA_W-2:0] exit_code_q,  exit_code_d;
    logic              proto_err_q,  proto_err_d;
    logic              timeout_q,    timeout_d;
    logic [WD_W-1:0]   wd_q,         wd_d;

    logic              wd_expire;
    logic              rx_clear;
    logic              rx_shift;
    logic              rx_parity;
    logic [DATA_W-1:0] rx_data;
    logic              rx_last;
    logic              rx_parity_ok;

    testrig_rx_shift #(
        .DATA_W (DATA_W)
    ) u_rx_shift (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (rx_clear),
        .shift_i     (rx_shift),
        .parity_i    (rx_parity),
        .bit_i       (testrig_tohost),
        .data_o      (rx_data),
        .last_o      (rx_last),
        .parity_ok_o (rx_parity_ok)
    );

    // Watchdog: counts from reset release and parks at TIMEOUT. The expiry
    // pulse fires on the edge that moves the count onto TIMEOUT, so timeout
    // is visible in cycle TIMEOUT after release.
    always_comb begin
        wd_d      = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);
        wd_expire = (wd_q == WD_LAST);
    end

    always_comb begin
        state_d      = state_q;
        word_valid_d = word_valid_q;
        word_data_d  = word_data_q;
        exit_valid_d = exit_valid_q;
        exit_code_d  = exit_code_q;
        proto_err_d  = proto_err_q;
        timeout_d    = timeout_q;
        rx_clear     = 1'b0;
        rx_shift     = 1'b0;
        rx_parity    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // fromhost_q is low for the first cycle after reset release,
                // so a start bit is only taken once the core has seen ready.
                if (fromhost_q && !testrig_tohost) begin
                    rx_clear = 1'b1;
                    state_d  = DATA;
                end
            end

            DATA: begin
                rx_shift = 1'b1;
                if (rx_last) begin
                    state_d = PARITY;
                end
            end

            PARITY: begin
                rx_parity = 1'b1;
                state_d   = STOP;
            end

            STOP: begin
                if (!testrig_tohost || !rx_parity_ok) begin
                    // Bad stop or parity: drop the frame, keep listening.
                    proto_err_d = 1'b1;
                    state_d     = IDLE;
                end else if (rx_data[EXIT_BIT]) begin
                    exit_valid_d = 1'b1;
                    exit_code_d  = rx_data[DATA_W-1:1];
                    state_d      = HALT;
                end else begin
                    word_valid_d = 1'b1;
                    word_data_d  = rx_data;
                    state_d      = HOLD;
                end
            end

            HOLD: begin
                // The core must wait for fromhost; a start bit here is a
                // protocol violation but is otherwise ignored.
                if (!testrig_tohost) begin
                    proto_err_d = 1'b1;
                end
                if (word_valid_q && word_ready) begin
                    word_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end

            HALT: begin
                state_d = HALT;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Watchdog overrides any frame or pending word. Checking state_d
        // rather than state_q lets an exit on the same edge take priority.
        if (wd_expire && (state_d != HALT)) begin
            timeout_d    = 1'b1;
            word_valid_d = 1'b0;
            state_d      = HALT;
        end
    end

    // Registered so fromhost stays low during reset and in the first cycle
    // after release, then tracks IDLE exactly.
    assign fromhost_d = (state_d == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            fromhost_q   <= 1'b0;
            word_valid_q <= 1'b0;
            word_data_q  <= '0;
            exit_valid_q <= 1'b0;
            exit_code_q  <= '0;
            proto_err_q  <= 1'b0;
            timeout_q    <= 1'b0;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            fromhost_q   <= fromhost_d;
            word_valid_q <= word_valid_d;
            word_data_q  <= word_data_d;
            exit_valid_q <= exit_valid_d;
            exit_code_q  <= exit_code_d;
            proto_err_q  <= proto_err_d;
            timeout_q    <= timeout_d;
            wd_q         <= wd_d;
        end
    end

    assign testrig_fromhost = fromhost_q;
    assign word_valid       = word_valid_q;
    assign word_data        = word_data_q;
    assign exit_valid       = exit_valid_q;
    assign exit_code        = exit_code_q;
    assign proto_err        = proto_err_q;
    assign timeout          = timeout_q;

endmodule : testrig_host

// File: tb/tb_testrig_host.sv
// -----------------------------------------------------------------------------
// tb_testrig_host
//   Self-checking bench for testrig_host. One instance uses the default
//   watchdog, a second uses TIMEOUT=100 for the watchdog scenarios. Inputs are
//   driven and outputs sampled on the falling edge; cycle 0 is the first cycle
//   after reset release. Data words are pushed to a scoreboard queue when the
//   frame is driven and popped when the consumer handshake happens.
// -----------------------------------------------------------------------------
module tb_testrig_host;

    typedef enum logic [1:0] {K_WORD, K_EXIT, K_BAD} kind_e;

    typedef struct {
        logic [31:0] data;
        logic        par;
        logic        stop;
        kind_e       kind;
        logic        rst_before;
        logic        exp_err;
        logic [30:0] exp_code;
    } vec_t;

    localparam int NV = 8;

    logic        clk;
    logic        rst;
    logic        tohost;
    logic        fromhost;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_ready;
    logic        exit_valid;
    logic [30:0] exit_code;
    logic        proto_err;
    logic        tmo;

    logic        t2_tohost;
    logic        t2_fromhost;
    logic        t2_word_valid;
    logic [31:0] t2_word_data;
    logic        t2_word_ready;
    logic        t2_exit_valid;
    logic [30:0] t2_exit_code;
    logic        t2_proto_err;
    logic        t2_timeout;

    int          errors;
    int          checks;
    int          cyc;
    logic [31:0] exp_q[$];
    logic [31:0] sb_word;
    vec_t        vecs[NV];

    testrig_host dut (
        .clk              (clk),
        .rst              (rst),
        .testrig_tohost   (tohost),
        .testrig_fromhost (fromhost),
        .word_valid       (word_valid),
        .word_data        (word_data),
        .word_ready       (word_ready),
        .exit_valid       (exit_valid),
        .exit_code        (exit_code),
        .proto_err        (proto_err),
        .timeout          (tmo)
    );

    testrig_host #(
        .TIMEOUT (100)
    ) dut_to (
        .clk              (clk),
        .rst              (rst),
        .testrig_tohost   (t2_tohost),
        .testrig_fromhost (t2_fromhost),
        .word_valid       (t2_word_valid),
        .word_data        (t2_word_data),
        .word_ready       (t2_word_ready),
        .exit_valid       (t2_exit_valid),
        .exit_code        (t2_exit_code),
        .proto_err        (t2_proto_err),
        .timeout          (t2_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drive(input bit sel, input logic b);
        if (sel) t2_tohost = b;
        else     tohost    = b;
    endtask

    // Reset both instances; returns at cycle 1 after release.
    task automatic do_reset();
        rst           = 1'b0;
        tohost        = 1'b1;
        t2_tohost     = 1'b1;
        word_ready    = 1'b1;
        t2_word_ready = 1'b0;
        step();
        check("rst_flags", 32'({fromhost, word_valid, exit_valid, proto_err, tmo}), 32'h0);
        check("rst_word_data", word_data, 32'h0);
        check("rst_exit_code", 32'(exit_code), 32'h0);
        check("sb_drained", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
        step();
        rst = 1'b1;
        cyc = 0;
        check("fromhost_cyc0", 32'(fromhost), 32'h0);
        step();
        check("fromhost_cyc1", 32'(fromhost), 32'h1);
    endtask

    // Drives a frame starting in the current cycle t; returns in cycle t+35.
    task automatic send_frame(input bit sel, input logic [31:0] data, input logic par,
                              input logic stop, input bit push);
        logic [31:0] d;
        d = data;
        if (!sel) check("ready_before_start", 32'(fromhost), 32'h1);
        drive(sel, 1'b0);
        step();
        if (!sel) check("busy_after_start", 32'(fromhost), 32'h0);
        for (int i = 0; i < 32; i++) begin
            drive(sel, d[i]);
            step();
        end
        drive(sel, par);
        step();
        if (!sel) check("busy_at_stop", 32'(fromhost), 32'h0);
        drive(sel, stop);
        if (push) exp_q.push_back(data);
        step();
        drive(sel, 1'b1);
    endtask

    // Scoreboard consumer side: compare at every handshake, away from edges.
    always @(negedge clk) begin
        #2;
        if (rst && word_valid && word_ready) begin
            check("sb_word_expected", 32'(exp_q.size() != 0), 32'h1);
            if (exp_q.size() != 0) begin
                sb_word = exp_q.pop_front();
                check("sb_word_data", word_data, sb_word);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL sim_time_limit: summary not reached, errors=%0d", errors);
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] part;
        errors = 0;
        checks = 0;
        cyc    = 0;

        vecs[0] = '{32'h0000_1234, 1'b1, 1'b1, K_WORD, 1'b1, 1'b0, 31'h0};
        vecs[1] = '{32'h0000_0055, 1'b0, 1'b1, K_EXIT, 1'b1, 1'b0, 31'h2A};
        vecs[2] = '{32'h0000_1234, 1'b0, 1'b1, K_BAD,  1'b1, 1'b1, 31'h0};
        vecs[3] = '{32'h0000_0008, 1'b1, 1'b1, K_WORD, 1'b0, 1'b1, 31'h0};
        vecs[4] = '{32'hDEAD_BEEE, 1'b1, 1'b0, K_BAD,  1'b1, 1'b1, 31'h0};
        vecs[5] = '{32'hFFFF_FFFE, 1'b1, 1'b1, K_WORD, 1'b0, 1'b1, 31'h0};
        vecs[6] = '{32'h8000_0000, 1'b1, 1'b1, K_WORD, 1'b1, 1'b0, 31'h0};
        vecs[7] = '{32'hFFFF_FFFF, 1'b0, 1'b1, K_EXIT, 1'b1, 1'b0, 31'h7FFF_FFFF};

        rst           = 1'b0;
        tohost        = 1'b1;
        t2_tohost     = 1'b1;
        word_ready    = 1'b1;
        t2_word_ready = 1'b0;
        @(negedge clk);

        // Table-driven frames on the default instance.
        for (int k = 0; k < NV; k++) begin
            if (vecs[k].rst_before) do_reset();
            step();
            step();
            send_frame(1'b0, vecs[k].data, vecs[k].par, vecs[k].stop, vecs[k].kind == K_WORD);
            check($sformatf("v%0d_word_valid_t35", k), 32'(word_valid), 32'(vecs[k].kind == K_WORD));
            check($sformatf("v%0d_exit_valid_t35", k), 32'(exit_valid), 32'(vecs[k].kind == K_EXIT));
            check($sformatf("v%0d_exit_code_t35", k), 32'(exit_code), 32'(vecs[k].exp_code));
            check($sformatf("v%0d_proto_err_t35", k), 32'(proto_err), 32'(vecs[k].exp_err));
            check($sformatf("v%0d_fromhost_t35", k), 32'(fromhost), 32'(vecs[k].kind == K_BAD));
            check($sformatf("v%0d_timeout_t35", k), 32'(tmo), 32'h0);
            step();
            check($sformatf("v%0d_word_valid_t36", k), 32'(word_valid), 32'h0);
            check($sformatf("v%0d_fromhost_t36", k), 32'(fromhost), 32'(vecs[k].kind != K_EXIT));
            check($sformatf("v%0d_exit_sticky_t36", k), 32'(exit_valid), 32'(vecs[k].kind == K_EXIT));
            check($sformatf("v%0d_proto_err_t36", k), 32'(proto_err), 32'(vecs[k].exp_err));
        end

        // Consumer stalls 10 cycles while the core glitches the line in HOLD.
        do_reset();
        step();
        word_ready = 1'b0;
        send_frame(1'b0, 32'h00C0_FFEE, 1'b0, 1'b1, 1'b1);
        check("hold_valid_t35", 32'(word_valid), 32'h1);
        check("hold_perr_before", 32'(proto_err), 32'h0);
        for (int i = 0; i < 10; i++) begin
            tohost = (i == 3) ? 1'b0 : 1'b1;
            step();
            check("hold_valid", 32'(word_valid), 32'h1);
            check("hold_data", word_data, 32'h00C0_FFEE);
            check("hold_fromhost", 32'(fromhost), 32'h0);
        end
        check("hold_perr_after", 32'(proto_err), 32'h1);
        tohost     = 1'b1;
        word_ready = 1'b1;
        step();
        check("hold_released_valid", 32'(word_valid), 32'h0);
        check("hold_released_fromhost", 32'(fromhost), 32'h1);

        // Reset pulsed while data bit 16 is on the line.
        do_reset();
        step();
        part   = 32'hA5A5_5A5A;
        tohost = 1'b0;
        step();
        for (int i = 0; i < 16; i++) begin
            tohost = part[i];
            step();
        end
        tohost = part[16];
        do_reset();
        step();
        send_frame(1'b0, 32'h0F0F_0F0E, 1'b1, 1'b1, 1'b1);
        check("midrst_word_valid", 32'(word_valid), 32'h1);
        check("midrst_proto_err", 32'(proto_err), 32'h0);
        step();
        check("midrst_word_done", 32'(word_valid), 32'h0);

        // Watchdog, no frames: timeout appears in cycle 100.
        do_reset();
        while (cyc < 99) step();
        check("wd_idle_c99_timeout", 32'(t2_timeout), 32'h0);
        check("wd_idle_c99_fromhost", 32'(t2_fromhost), 32'h1);
        step();
        check("wd_idle_c100_timeout", 32'(t2_timeout), 32'h1);
        check("wd_idle_c100_fromhost", 32'(t2_fromhost), 32'h0);
        step();
        step();
        check("wd_idle_later_fromhost", 32'(t2_fromhost), 32'h0);
        check("wd_idle_later_timeout", 32'(t2_timeout), 32'h1);

        // Exit stop bit sampled on the same edge the watchdog expires.
        do_reset();
        while (cyc < 65) step();
        send_frame(1'b1, 32'h0000_0003, 1'b0, 1'b1, 1'b0);
        check("wd_tie_cycle", 32'(cyc), 32'd100);
        check("wd_tie_exit_valid", 32'(t2_exit_valid), 32'h1);
        check("wd_tie_exit_code", 32'(t2_exit_code), 32'h1);
        check("wd_tie_timeout", 32'(t2_timeout), 32'h0);
        step();
        step();
        check("wd_tie_timeout_later", 32'(t2_timeout), 32'h0);

        // Watchdog expires while a word waits in HOLD.
        do_reset();
        while (cyc < 10) step();
        send_frame(1'b1, 32'h0000_1234, 1'b1, 1'b1, 1'b0);
        check("wd_hold_valid_t35", 32'(t2_word_valid), 32'h1);
        while (cyc < 99) step();
        check("wd_hold_c99_valid", 32'(t2_word_valid), 32'h1);
        step();
        check("wd_hold_c100_valid", 32'(t2_word_valid), 32'h0);
        check("wd_hold_c100_timeout", 32'(t2_timeout), 32'h1);
        check("wd_hold_c100_fromhost", 32'(t2_fromhost), 32'h0);

        // Watchdog expires mid-frame; the rest of the frame is ignored.
        do_reset();
        while (cyc < 80) step();
        send_frame(1'b1, 32'h0000_0003, 1'b0, 1'b1, 1'b0);
        check("wd_frame_timeout", 32'(t2_timeout), 32'h1);
        check("wd_frame_exit_valid", 32'(t2_exit_valid), 32'h0);
        check("wd_frame_proto_err", 32'(t2_proto_err), 32'h0);
        check("wd_frame_fromhost", 32'(t2_fromhost), 32'h0);

        check("sb_final_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_testrig_host
